// File: rtl/oven_cook_timer.sv
`default_nettype none
// ============================================================================
// Module   : oven_cook_timer
// Brief    : Preheat delay and tick-based cook timer feeding the oven controller.
// Revision : 1.0 - initial release
// ============================================================================
module oven_cook_timer #(
    parameter int PREHEAT_CYCLES = 16,
    parameter int TICK_DIV       = 4,
    parameter int TIME_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              heat,
    input  logic              load,
    input  logic              unload,
    input  logic [TIME_W-1:0] cook_time,
    output logic              temp_ok,
    output logic              done,
    output logic [TIME_W-1:0] remaining,
    output logic              busy
);

    localparam int c_PRE_W  = (PREHEAT_CYCLES > 1) ? $clog2(PREHEAT_CYCLES) : 1;
    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_INIT  = c_PRE_W'(PREHEAT_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_INIT = c_TICK_W'(TICK_DIV - 1);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_PREHEAT = 3'd1;
    localparam logic [2:0] c_S_READY   = 3'd2;
    localparam logic [2:0] c_S_COOKING = 3'd3;
    localparam logic [2:0] c_S_DONE    = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic [c_PRE_W-1:0]  w_pre_next;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TICK_W-1:0] w_tick_next;
    logic [TIME_W-1:0]   r_remaining;
    logic [TIME_W-1:0]   w_rem_next;
    logic [TIME_W-1:0]   w_units;
    logic                r_temp_ok;
    logic                r_done;
    logic                r_busy;
    logic                w_temp_ok_next;
    logic                w_done_next;
    logic                w_busy_next;

    // A zero request still cooks for one unit.
    assign w_units = (cook_time == '0) ? TIME_W'(1) : cook_time;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_pre_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_remaining <= '0;
            r_temp_ok   <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pre_cnt   <= w_pre_next;
            r_tick_cnt  <= w_tick_next;
            r_remaining <= w_rem_next;
            r_temp_ok   <= w_temp_ok_next;
            r_done      <= w_done_next;
            r_busy      <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pre_next   = r_pre_cnt;
        w_tick_next  = r_tick_cnt;
        w_rem_next   = r_remaining;
        case (r_state)
            c_S_IDLE: begin
                if (heat) begin
                    w_state_next = c_S_PREHEAT;
                    w_pre_next   = c_PRE_INIT;
                end
            end
            c_S_PREHEAT: begin
                if (!heat) begin
                    w_state_next = c_S_IDLE;
                end else if (r_pre_cnt == '0) begin
                    w_state_next = c_S_READY;
                end else begin
                    w_pre_next = r_pre_cnt - c_PRE_W'(1);
                end
            end
            c_S_READY: begin
                if (!heat) begin
                    w_state_next = c_S_IDLE;
                end else if (load) begin
                    w_state_next = c_S_COOKING;
                    w_rem_next   = w_units;
                    w_tick_next  = c_TICK_INIT;
                end
            end
            c_S_COOKING: begin
                if (!heat) begin
                    w_state_next = c_S_IDLE;
                end else if (r_tick_cnt == '0) begin
                    w_tick_next = c_TICK_INIT;
                    if (r_remaining <= TIME_W'(1)) begin
                        w_state_next = c_S_DONE;
                        w_rem_next   = '0;
                    end else begin
                        w_rem_next = r_remaining - TIME_W'(1);
                    end
                end else begin
                    w_tick_next = r_tick_cnt - c_TICK_W'(1);
                end
            end
            c_S_DONE: begin
                if (!heat || unload) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
        // Every route into IDLE (abort, unload, bad encoding) leaves counters clean.
        if (w_state_next == c_S_IDLE) begin
            w_pre_next  = '0;
            w_tick_next = '0;
            w_rem_next  = '0;
        end
    end

    // Flag outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_temp_ok_next = 1'b0;
        w_done_next    = 1'b0;
        w_busy_next    = 1'b0;
        case (w_state_next)
            c_S_PREHEAT: begin
                w_busy_next = 1'b1;
            end
            c_S_READY, c_S_COOKING: begin
                w_busy_next    = 1'b1;
                w_temp_ok_next = 1'b1;
            end
            c_S_DONE: begin
                w_busy_next    = 1'b1;
                w_temp_ok_next = 1'b1;
                w_done_next    = 1'b1;
            end
            default: begin
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign temp_ok   = r_temp_ok;
    assign done      = r_done;
    assign busy      = r_busy;
    assign remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_oven_cook_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oven_cook_timer
// Brief    : Two oven_cook_timer instances (default and 1/1 timing) against an
//            elapsed-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oven_cook_timer;

    logic       clock = 1'b0;
    logic       reset, heat, load, unload;
    logic [7:0] cook_time;

    logic       t0, d0, b0, t1, d1, b1;
    logic [7:0] r0, r1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_edge = 0;

    int m_p[2];
    int m_d[2];
    bit m_active[2];
    bit m_loaded[2];
    int m_heat_edge[2];
    int m_load_edge[2];
    int m_units[2];

    always #5 clock = ~clock;

    oven_cook_timer dut0 (
        .clock(clock), .reset(reset), .heat(heat), .load(load), .unload(unload),
        .cook_time(cook_time), .temp_ok(t0), .done(d0), .remaining(r0), .busy(b0)
    );

    oven_cook_timer #(.PREHEAT_CYCLES(1), .TICK_DIV(1), .TIME_W(8)) dut1 (
        .clock(clock), .reset(reset), .heat(heat), .load(load), .unload(unload),
        .cook_time(cook_time), .temp_ok(t1), .done(d1), .remaining(r1), .busy(b1)
    );

    // Expected {busy, temp_ok, done, remaining} from elapsed edges since heat/load.
    function automatic logic [10:0] model_exp(int k);
        logic bz, tk, dn;
        logic [7:0] rem;
        int el;
        bz  = m_active[k];
        tk  = m_active[k] && (n_edge - m_heat_edge[k] >= m_p[k]);
        dn  = 1'b0;
        rem = 8'd0;
        if (m_active[k] && m_loaded[k]) begin
            el = n_edge - m_load_edge[k];
            dn = (el >= m_units[k] * m_d[k]);
            if (!dn) rem = 8'(m_units[k] - el / m_d[k]);
        end
        return {bz, tk, dn, rem};
    endfunction

    function automatic logic [10:0] observed(int k);
        return (k == 0) ? {b0, t0, d0, r0} : {b1, t1, d1, r1};
    endfunction

    task automatic step(input logic h, input logic l, input logic u,
                        input logic [7:0] ct, input logic rs);
        bit prev_ready, prev_done;
        reset = rs; heat = h; load = l; unload = u; cook_time = ct;
        @(posedge clock);
        n_edge++;
        for (int k = 0; k < 2; k++) begin
            prev_ready = m_active[k] && !m_loaded[k] && (n_edge - 1 - m_heat_edge[k] >= m_p[k]);
            prev_done  = m_active[k] && m_loaded[k] &&
                         (n_edge - 1 - m_load_edge[k] >= m_units[k] * m_d[k]);
            if (rs) begin
                m_active[k] = 0;
            end else if (!m_active[k]) begin
                if (h) begin
                    m_active[k] = 1; m_loaded[k] = 0; m_heat_edge[k] = n_edge;
                end
            end else if (!h) begin
                m_active[k] = 0;
            end else if (prev_ready && l) begin
                m_loaded[k] = 1; m_load_edge[k] = n_edge;
                m_units[k] = (ct == 8'd0) ? 1 : int'(ct);
            end else if (prev_done && u) begin
                m_active[k] = 0;
            end
        end
        #1;
    endtask

    task automatic go_idle();
        repeat (2) step(0, 0, 0, 8'd0, 0);
    endtask

    task automatic to_ready();
        repeat (17) step(1, 0, 0, 8'd0, 0);
    endtask

    task automatic test_reset();
        repeat (2) step(0, 0, 0, 8'd0, 1);
        step(1, 1, 1, 8'd7, 1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (observed(k) !== model_exp(k)) begin
                n_bad++;
                $display("FAIL reset dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
            end
        end
        n_cmp++;
        if ({b0, t0, d0, r0} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_zero: got %h want 000", {b0, t0, d0, r0});
        end
    endtask

    task automatic test_nominal();
        int rise_t, rise_d;
        rise_t = -1; rise_d = -1;
        go_idle();
        step(1, 0, 0, 8'd3, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0, 8'd3, 0);
            if (t0 && rise_t < 0) rise_t = i;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL nominal_preheat dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (rise_t !== 16) begin
            n_bad++;
            $display("FAIL nominal_temp_ok_latency: got %0d want 16", rise_t);
        end
        step(1, 1, 0, 8'd3, 0);
        for (int i = 1; i <= 15; i++) begin
            step(1, 0, 0, 8'd3, 0);
            if (d0 && rise_d < 0) rise_d = i;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL nominal_cook dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (rise_d !== 12) begin
            n_bad++;
            $display("FAIL nominal_done_latency: got %0d want 12", rise_d);
        end
        step(1, 0, 1, 8'd3, 0);
        n_cmp++;
        if ({b0, t0, d0, r0} !== 11'd0) begin
            n_bad++;
            $display("FAIL nominal_unload: got %h want 000", {b0, t0, d0, r0});
        end
    endtask

    task automatic test_cook_zero();
        int rise_d;
        rise_d = -1;
        go_idle();
        to_ready();
        step(1, 1, 0, 8'd0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, 0, 8'd0, 0);
            if (d0 && rise_d < 0) rise_d = i;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL cook_zero dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (rise_d !== 4) begin
            n_bad++;
            $display("FAIL cook_zero_latency: got %0d want 4", rise_d);
        end
    endtask

    task automatic test_abort();
        bit seen;
        seen = 0;
        go_idle();
        step(1, 0, 0, 8'd0, 0);
        for (int i = 1; i <= 12; i++) begin
            step(i < 7, 0, 0, 8'd0, 0);
            if (t0) seen = 1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL abort_preheat dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_preheat_temp_ok: got %0d want 0", seen);
        end
        seen = 0;
        to_ready();
        step(1, 1, 0, 8'd5, 0);
        for (int i = 1; i <= 30; i++) begin
            step(i < 9, 0, 0, 8'd5, 0);
            if (d0) seen = 1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL abort_cooking dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_cooking_done: got %0d want 0", seen);
        end
    endtask

    task automatic test_ignored();
        int rise_d;
        rise_d = -1;
        go_idle();
        step(1, 0, 0, 8'd9, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1, i == 5, 1, 8'd9, 0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL ignored_preheat dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        step(1, 1, 0, 8'd2, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, i == 3, i == 5, 8'd7, 0);
            if (d0 && rise_d < 0) rise_d = i;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL ignored_cooking dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (rise_d !== 8) begin
            n_bad++;
            $display("FAIL ignored_done_latency: got %0d want 8", rise_d);
        end
    endtask

    task automatic test_same_cycle_abort_load();
        go_idle();
        to_ready();
        step(0, 1, 0, 8'd5, 0);
        step(0, 0, 0, 8'd5, 0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (observed(k) !== model_exp(k)) begin
                n_bad++;
                $display("FAIL abort_vs_load dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
            end
        end
        n_cmp++;
        if ({b0, r0} !== 9'd0) begin
            n_bad++;
            $display("FAIL abort_vs_load_remaining: got %h want 000", {b0, r0});
        end
    endtask

    task automatic test_reset_mid_cook();
        go_idle();
        to_ready();
        step(1, 1, 0, 8'd8, 0);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 8'd8, 0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL mid_cook dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (r0 !== 8'd5) begin
            n_bad++;
            $display("FAIL mid_cook_remaining: got %0d want 5", r0);
        end
        step(1, 0, 0, 8'd8, 1);
        n_cmp++;
        if ({b0, t0, d0, r0} !== 11'd0) begin
            n_bad++;
            $display("FAIL mid_cook_reset: got %h want 000", {b0, t0, d0, r0});
        end
        step(1, 0, 0, 8'd8, 0);
        n_cmp++;
        if ({b0, t0, d0} !== 3'b100) begin
            n_bad++;
            $display("FAIL fresh_preheat: got %b want 100", {b0, t0, d0});
        end
    endtask

    task automatic test_param_sweep();
        int rise_d;
        rise_d = -1;
        go_idle();
        step(1, 0, 0, 8'd255, 0);
        step(1, 0, 0, 8'd255, 0);
        n_cmp++;
        if (t1 !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_temp_ok_latency: got %b want 1", t1);
        end
        step(1, 1, 0, 8'd255, 0);
        for (int i = 1; i <= 260; i++) begin
            step(1, 0, 0, 8'd255, 0);
            if (d1 && rise_d < 0) rise_d = i;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL sweep dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
        n_cmp++;
        if (rise_d !== 255) begin
            n_bad++;
            $display("FAIL sweep_done_latency: got %0d want 255", rise_d);
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(63) != 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                 8'($urandom_range(6)), $urandom_range(255) == 0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (observed(k) !== model_exp(k)) begin
                    n_bad++;
                    $display("FAIL random dut%0d edge %0d: got %h want %h", k, n_edge, observed(k), model_exp(k));
                end
            end
        end
    endtask

    initial begin
        m_p = '{16, 1};
        m_d = '{4, 1};
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0; m_loaded[k] = 0;
            m_heat_edge[k] = 0; m_load_edge[k] = 0; m_units[k] = 1;
        end
        reset = 1'b1; heat = 1'b0; load = 1'b0; unload = 1'b0; cook_time = 8'd0;
        test_reset();
        test_nominal();
        test_cook_zero();
        test_abort();
        test_ignored();
        test_same_cycle_abort_load();
        test_reset_mid_cook();
        test_param_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oven_cook_timer.md
Name: oven_cook_timer

Overview:
- Timing/sensor-emulation stage directly upstream of the oven controller FSM.
- Watches the controller's heat, load and unload outputs and generates its temp_ok and done inputs.
- temp_ok: fixed preheat delay measured from heat assertion.
- done: programmable cook duration measured from the load pulse, counted in coarse ticks.
- Also exports remaining cook time and a busy flag for display/status logic.

Parameters:
- PREHEAT_CYCLES, 16: clock edges from first sampled heat=1 to temp_ok rising; legal range >=1.
- TICK_DIV, 4: clock cycles per cook-time unit; legal range >=1.
- TIME_W, 8: width of cook_time and remaining.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- heat  in  1  heater-on from the oven controller.
- load  in  1  one-cycle food-load pulse from the oven controller.
- unload  in  1  one-cycle unload pulse from the oven controller.
- cook_time  in  TIME_W  requested cook duration in units of TICK_DIV cycles; sampled only on an accepted load.
- temp_ok  out  1  heater at temperature.
- done  out  1  cook complete; held until cleared.
- remaining  out  TIME_W  cook units left; 0 outside COOKING.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, PREHEAT, READY, COOKING, DONE. All outputs are registered, with no combinational input-to-output path.
- Reset: sampled reset=1 forces IDLE on that edge. Outputs become temp_ok=0, done=0, remaining=0, busy=0, and all counters clear. Reset overrides every other input, including mid-cook.
- Abort rule: in any non-IDLE state, heat=0 at an edge forces IDLE on that edge and clears outputs as on reset. Abort has priority over load and unload in the same cycle.
- IDLE: heat=1 -> PREHEAT, preheat counter loaded with PREHEAT_CYCLES-1, busy=1 on that edge.
- PREHEAT:
  - Counter decrements each edge.
  - When counter==0 at an edge, go to READY and set temp_ok=1. temp_ok is first visible exactly PREHEAT_CYCLES edges after the edge that sampled heat=1.
  - load is ignored in this state.
- READY: load=1 -> COOKING.
  - Latch units = (cook_time==0) ? 1 : cook_time.
  - remaining = units; tick counter = TICK_DIV-1.
- COOKING:
  - Tick counter decrements each edge. On wrap (counter==0), reload to TICK_DIV-1 and decrement remaining.
  - When remaining==1 and the tick wraps, go to DONE with done=1 and remaining=0.
  - done therefore rises exactly units*TICK_DIV edges after the load-sampling edge.
  - Further load pulses are ignored; there is no restart. cook_time changes have no effect.
- DONE: done=1 and temp_ok=1 hold. unload=1 -> IDLE, which clears done, temp_ok and busy on that edge.
- temp_ok is 1 in READY, COOKING and DONE, and 0 in IDLE and PREHEAT.
- unload in any state other than DONE is ignored, unless heat=0 triggers the abort rule.
- Illegal or unused state encodings go to IDLE on the next edge.
- Counter widths: the preheat counter is sized for PREHEAT_CYCLES-1 and the tick counter for TICK_DIV-1. remaining never underflows; it saturates at 0.

Test Plan:
- Reset mid-COOKING with remaining=5 -> next edge: busy=0, temp_ok=0, done=0, remaining=0; a later heat pulse starts a fresh PREHEAT.
- Nominal closed loop with the oven controller, defaults, cook_time=3:
  - temp_ok rises 16 edges after heat is sampled.
  - load pulse -> remaining=3, which drops to 2, 1 and 0 at 4-cycle intervals.
  - done rises 12 edges after load; unload -> IDLE with all outputs 0.
- cook_time=0 on load -> treated as 1; done rises 4 edges after load (TICK_DIV=4).
- heat dropped during PREHEAT (edge 7) and separately during COOKING -> IDLE next edge; temp_ok never asserted in the first case; done never asserted in the second.
- load during PREHEAT, a second load during COOKING, and unload during COOKING -> all ignored; done timing is unchanged from the first accepted load.
- Same-cycle heat=0 and load=1 in READY -> IDLE; remaining stays 0.
- Parameter sweep with PREHEAT_CYCLES=1 and TICK_DIV=1, cook_time=255 -> temp_ok one edge after heat; done 255 edges after load; remaining decrements every cycle.
